// File: rtl/udp_deframer_pkg.sv
// Shared definitions for the UDP payload deframer.
// Holds the deframer FSM state encoding, the default MAGIC header value
// and small helpers used by the top level and the byte packer.
package udp_deframer_pkg;

    localparam logic [15:0] MAGIC_DEFAULT = 16'hD0A5;

    typedef enum logic [2:0] {
        HDR0    = 3'd0,
        HDR1    = 3'd1,
        SEQ0    = 3'd2,
        SEQ1    = 3'd3,
        PAYLOAD = 3'd4,
        DROP    = 3'd5
    } state_t;

    // tkeep for a word whose last byte lands in lane cnt (0 = only [31:24] valid)
    function automatic logic [3:0] keep_for_count(input logic [1:0] cnt);
        logic [3:0] keep;
        case (cnt)
            2'd0:    keep = 4'b1000;
            2'd1:    keep = 4'b1100;
            2'd2:    keep = 4'b1110;
            default: keep = 4'b1111;
        endcase
        return keep;
    endfunction

    // Sequence numbers wrap, so FFFF -> 0000 is the expected successor.
    function automatic logic [15:0] seq_next(input logic [15:0] seq);
        return seq + 16'd1;
    endfunction

endpackage

// File: rtl/byte_packer_32.sv
// Packs a byte stream into big-endian 32-bit words with tkeep and a
// one-deep output hold register.
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   i_valid              payload byte offered (only while the FSM is in PAYLOAD)
//   i_data/i_last/i_user payload byte, end-of-packet marker, error flag
//   o_ready              byte can be taken this cycle
//   m_axis_*             packed word stream (AXI-Stream master)
module byte_packer_32
    import udp_deframer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    input  logic        i_last,
    input  logic        i_user,
    output logic        o_ready,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser
);

    logic [7:0]  r_b0;
    logic [7:0]  r_b1;
    logic [7:0]  r_b2;
    logic [1:0]  r_cnt;
    logic [31:0] r_tdata;
    logic [3:0]  r_tkeep;
    logic        r_tvalid;
    logic        r_tlast;
    logic        r_tuser;

    logic        w_accept;
    logic        w_flush;
    logic        w_pop;
    logic [31:0] w_word;

    // A new byte may enter whenever the hold register is empty or draining
    // this cycle; bytes that only fill the accumulator are held off too,
    // which keeps the ready logic a single term.
    assign o_ready  = ~r_tvalid | m_axis_tready;
    assign w_accept = i_valid & o_ready;
    assign w_flush  = w_accept & (i_last | (r_cnt == 2'd3));
    assign w_pop    = r_tvalid & m_axis_tready;

    // Current byte completes the word; unused low lanes are zero.
    always_comb begin
        w_word = 32'h0;
        case (r_cnt)
            2'd0:    w_word = {i_data, 24'h0};
            2'd1:    w_word = {r_b0, i_data, 16'h0};
            2'd2:    w_word = {r_b0, r_b1, i_data, 8'h0};
            default: w_word = {r_b0, r_b1, r_b2, i_data};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b0     <= 8'h0;
            r_b1     <= 8'h0;
            r_b2     <= 8'h0;
            r_cnt    <= 2'd0;
            r_tdata  <= 32'h0;
            r_tkeep  <= 4'h0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tuser  <= 1'b0;
        end else begin
            if (w_accept) begin
                if (r_cnt == 2'd0) r_b0 <= i_data;
                if (r_cnt == 2'd1) r_b1 <= i_data;
                if (r_cnt == 2'd2) r_b2 <= i_data;
                r_cnt <= w_flush ? 2'd0 : r_cnt + 2'd1;
            end
            if (w_flush) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_word;
                r_tkeep  <= keep_for_count(r_cnt);
                r_tlast  <= i_last;
                r_tuser  <= i_last & i_user;
            end else if (w_pop) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tuser  = r_tuser;

endmodule

// File: rtl/udp_payload_deframer.sv
// Strips the 4-byte header (MAGIC + sequence number) from UDP payloads and
// repacks the remaining bytes into 32-bit words. Reports per-packet status
// and optional sequence-gap events.
//
// Ports
//   clk, rst_n      clock, async active-low reset
//   s_axis_*        8-bit UDP RX payload stream (tuser on tlast = bad packet)
//   m_axis_*        32-bit packed sample words, tkeep marks valid lanes
//   last_seq        sequence number of the most recent accepted packet
//   stat_pkt_ok     one-cycle pulse per accepted packet
//   stat_pkt_bad    one-cycle pulse per rejected packet
//   stat_seq_gap    one-cycle pulse when an accepted packet skips sequence
//
// state   | meaning
// --------+--------------------------------------------------------------
// HDR0    | expecting MAGIC high byte (first byte of a packet)
// HDR1    | expecting MAGIC low byte
// SEQ0    | capturing sequence number high byte
// SEQ1    | capturing sequence number low byte
// PAYLOAD | forwarding bytes to the packer until tlast
// DROP    | header mismatch, discarding bytes until tlast
module udp_payload_deframer
    import udp_deframer_pkg::*;
#(
    parameter logic [15:0] MAGIC     = MAGIC_DEFAULT,
    parameter bit          CHECK_SEQ = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic [15:0] last_seq,
    output logic        stat_pkt_ok,
    output logic        stat_pkt_bad,
    output logic        stat_seq_gap
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_seq;
    logic [15:0] r_last_seq;
    logic        r_seen_first;
    logic        r_stat_ok;
    logic        r_stat_bad;
    logic        r_stat_gap;

    logic        w_beat;
    logic        w_pk_valid;
    logic        w_pk_ready;
    logic        w_pkt_ok;
    logic        w_pkt_bad;
    logic        w_gap;
    logic [15:0] w_seq_cur;

    // Only PAYLOAD can back-pressure; rst_n gates ready so nothing is taken
    // while the block is held in reset.
    assign s_axis_tready = rst_n & ((r_state != PAYLOAD) | w_pk_ready);
    assign w_beat        = s_axis_tvalid & s_axis_tready;

    always_comb begin
        w_state_nxt = r_state;
        w_pkt_ok    = 1'b0;
        w_pkt_bad   = 1'b0;
        w_pk_valid  = 1'b0;
        w_seq_cur   = r_seq;
        case (r_state)
            HDR0: begin
                if (w_beat) begin
                    if (s_axis_tlast)                       w_pkt_bad   = 1'b1;
                    else if (s_axis_tdata == MAGIC[15:8])   w_state_nxt = HDR1;
                    else                                    w_state_nxt = DROP;
                end
            end
            HDR1: begin
                if (w_beat) begin
                    if (s_axis_tlast) begin
                        w_pkt_bad   = 1'b1;
                        w_state_nxt = HDR0;
                    end else if (s_axis_tdata == MAGIC[7:0]) begin
                        w_state_nxt = SEQ0;
                    end else begin
                        w_state_nxt = DROP;
                    end
                end
            end
            SEQ0: begin
                if (w_beat) begin
                    if (s_axis_tlast) begin
                        w_pkt_bad   = 1'b1;
                        w_state_nxt = HDR0;
                    end else begin
                        w_state_nxt = SEQ1;
                    end
                end
            end
            SEQ1: begin
                // Low byte arrives now; a header-only packet is judged on it.
                w_seq_cur = {r_seq[15:8], s_axis_tdata};
                if (w_beat) begin
                    if (s_axis_tlast) begin
                        w_pkt_ok    = 1'b1;
                        w_state_nxt = HDR0;
                    end else begin
                        w_state_nxt = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                w_pk_valid = s_axis_tvalid;
                if (w_beat && s_axis_tlast) begin
                    if (s_axis_tuser) w_pkt_bad = 1'b1;
                    else              w_pkt_ok  = 1'b1;
                    w_state_nxt = HDR0;
                end
            end
            DROP: begin
                if (w_beat && s_axis_tlast) begin
                    w_pkt_bad   = 1'b1;
                    w_state_nxt = HDR0;
                end
            end
            default: w_state_nxt = HDR0;
        endcase
    end

    assign w_gap = CHECK_SEQ && w_pkt_ok && r_seen_first &&
                   (w_seq_cur != seq_next(r_last_seq));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HDR0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq        <= 16'h0;
            r_last_seq   <= 16'h0;
            r_seen_first <= 1'b0;
            r_stat_ok    <= 1'b0;
            r_stat_bad   <= 1'b0;
            r_stat_gap   <= 1'b0;
        end else begin
            if (w_beat && (r_state == SEQ0)) r_seq[15:8] <= s_axis_tdata;
            if (w_beat && (r_state == SEQ1)) r_seq[7:0]  <= s_axis_tdata;
            if (w_pkt_ok) begin
                r_last_seq   <= w_seq_cur;
                r_seen_first <= 1'b1;
            end
            r_stat_ok  <= w_pkt_ok;
            r_stat_bad <= w_pkt_bad;
            r_stat_gap <= w_gap;
        end
    end

    byte_packer_32 u_packer (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_valid       (w_pk_valid),
        .i_data        (s_axis_tdata),
        .i_last        (s_axis_tlast),
        .i_user        (s_axis_tuser),
        .o_ready       (w_pk_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser)
    );

    assign last_seq     = r_last_seq;
    assign stat_pkt_ok  = r_stat_ok;
    assign stat_pkt_bad = r_stat_bad;
    assign stat_seq_gap = r_stat_gap;

endmodule

// File: tb/tb_udp_payload_deframer.sv
module tb_udp_payload_deframer;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        u;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_axis_tdata = 8'h0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic [15:0] last_seq;
    logic        stat_pkt_ok;
    logic        stat_pkt_bad;
    logic        stat_seq_gap;

    udp_payload_deframer #(.MAGIC(16'hD0A5), .CHECK_SEQ(1'b1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .last_seq      (last_seq),
        .stat_pkt_ok   (stat_pkt_ok),
        .stat_pkt_bad  (stat_pkt_bad),
        .stat_seq_gap  (stat_seq_gap)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cnt_ok = 0, cnt_bad = 0, cnt_gap = 0;
    int          exp_ok = 0, exp_bad = 0, exp_gap = 0;
    logic [15:0] exp_last_seq = 16'h0;
    bit          m_seen = 1'b0;
    logic [15:0] m_prev = 16'h0;
    bit          rand_ready = 1'b0;
    bit          gaps = 1'b0;
    logic [15:0] magic = 16'hD0A5;
    logic [7:0]  pkt[$];
    word_t       got_q[$];
    word_t       exp_q[$];
    word_t       prev_w, cur_w;
    bit          prev_stall = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sink ready: changes just after each rising edge, random when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: collects words, counts status pulses, checks holding.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            cur_w = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
            if (prev_stall) begin
                check("hold_valid", 64'(m_axis_tvalid), 64'd1);
                check("hold_word", 64'(cur_w), 64'(prev_w));
            end
            if (m_axis_tvalid && m_axis_tready) got_q.push_back(cur_w);
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_w = cur_w;
            if (stat_pkt_ok)  cnt_ok++;
            if (stat_pkt_bad) cnt_bad++;
            if (stat_seq_gap) cnt_gap++;
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] d, input bit l, input bit u);
        int guard = 0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            s_axis_tvalid = 1'b0;
            s_axis_tdata  = 8'($urandom);
            s_axis_tlast  = 1'($urandom_range(0, 1));
            align();
        end
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        @(negedge clk);
        while (s_axis_tready !== 1'b1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("tready_wait", 64'(s_axis_tready), 64'd1);
        align();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    // Packet-level reference: header rules, big-endian chunking, seq tracking.
    task automatic model_pkt(input bit user);
        int n = pkt.size();
        logic [15:0] seq;
        logic [15:0] nxt;
        if (n < 4 || pkt[0] != magic[15:8] || pkt[1] != magic[7:0]) begin
            exp_bad++;
            return;
        end
        seq = {pkt[2], pkt[3]};
        for (int i = 4; i < n; i += 4) begin
            word_t w;
            w = '0;
            for (int k = 0; k < 4; k++) begin
                if (i + k < n) begin
                    w.d[31 - 8*k -: 8] = pkt[i + k];
                    w.k[3 - k] = 1'b1;
                end
            end
            w.l = (i + 4 >= n);
            w.u = w.l && user;
            exp_q.push_back(w);
        end
        if (n > 4 && user) begin
            exp_bad++;
        end else begin
            exp_ok++;
            if (m_seen) begin
                nxt = m_prev + 16'd1;
                if (seq != nxt) exp_gap++;
            end
            m_seen = 1'b1;
            m_prev = seq;
            exp_last_seq = seq;
        end
    endtask

    task automatic send_pkt(input bit user);
        int n = pkt.size();
        for (int i = 0; i < n; i++)
            send_byte(pkt[i], i == n - 1, (i == n - 1) ? user : 1'($urandom_range(0, 1)));
        model_pkt(user);
    endtask

    task automatic build_hdr(input logic [15:0] seq);
        pkt.delete();
        pkt.push_back(8'hD0);
        pkt.push_back(8'hA5);
        pkt.push_back(seq[15:8]);
        pkt.push_back(seq[7:0]);
    endtask

    task automatic add_payload(input int n);
        for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
    endtask

    task automatic verify(input string tag);
        int guard = 0;
        while (got_q.size() < exp_q.size() && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        check({tag, " word_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s word%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        check({tag, " pkt_ok"},   64'(cnt_ok),  64'(exp_ok));
        check({tag, " pkt_bad"},  64'(cnt_bad), 64'(exp_bad));
        check({tag, " seq_gap"},  64'(cnt_gap), 64'(exp_gap));
        check({tag, " last_seq"}, 64'(last_seq), 64'(exp_last_seq));
        got_q.delete();
        exp_q.delete();
        align();
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        @(negedge clk);
        check({tag, " rst tready"}, 64'(s_axis_tready), 64'd0);
        check({tag, " rst tvalid"}, 64'(m_axis_tvalid), 64'd0);
        check({tag, " rst word"},
              64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 64'd0);
        check({tag, " rst last_seq"}, 64'(last_seq), 64'd0);
        check({tag, " rst stats"},
              64'({stat_pkt_ok, stat_pkt_bad, stat_seq_gap}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_seen = 1'b0;
        exp_last_seq = 16'h0;
        @(negedge clk);
        check({tag, " post-rst tready"}, 64'(s_axis_tready), 64'd1);
        align();
    endtask

    initial begin
        int kind;
        int len;
        logic [15:0] seq;

        do_reset("init");

        // Directed: two full words, seq 0x0007.
        pkt = '{8'hD0, 8'hA5, 8'h00, 8'h07, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88};
        send_pkt(1'b0);
        verify("full_words");
        check("full_words seq7", 64'(last_seq), 64'h0007);

        // Directed: short final word.
        pkt = '{8'hD0, 8'hA5, 8'h00, 8'h08, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        send_pkt(1'b0);
        verify("short_word");

        // Directed: bad magic low byte.
        pkt = '{8'hD0, 8'hA6, 8'h00, 8'h09, 8'h01, 8'h02};
        send_pkt(1'b0);
        verify("bad_magic");
        check("bad_magic seq kept", 64'(last_seq), 64'h0008);

        // Sequence wrap, from a fresh reset.
        do_reset("pre_seq");
        build_hdr(16'hFFFF); add_payload(3); send_pkt(1'b0);
        build_hdr(16'h0000); add_payload(5); send_pkt(1'b0);
        build_hdr(16'h0002); add_payload(2); send_pkt(1'b0);
        verify("seq_wrap");

        // Header-only, truncated headers, errored payload packet.
        build_hdr(16'h0003); send_pkt(1'b0);
        pkt = '{8'hD0};               send_pkt(1'b0);
        pkt = '{8'hD0, 8'hA5};        send_pkt(1'b0);
        pkt = '{8'hD0, 8'hA5, 8'h00}; send_pkt(1'b0);
        pkt = '{8'h55};               send_pkt(1'b0);
        build_hdr(16'h0004); add_payload(7); send_pkt(1'b1);
        verify("edge_pkts");

        // 64-byte payload with a randomly stalling sink.
        rand_ready = 1'b1;
        build_hdr(16'h0004); add_payload(64); send_pkt(1'b0);
        verify("stall64");

        // Random traffic.
        gaps = 1'b1;
        seq = 16'h0005;
        for (int p = 0; p < 25; p++) begin
            kind = $urandom_range(0, 5);
            if (kind == 0) begin
                len = $urandom_range(1, 12);
                pkt.delete();
                pkt.push_back(8'h5A);
                add_payload(len - 1);
                send_pkt(1'($urandom_range(0, 1)));
            end else if (kind == 1) begin
                build_hdr(seq);
                len = $urandom_range(1, 3);
                while (pkt.size() > len) void'(pkt.pop_back());
                send_pkt(1'b0);
            end else if (kind == 2) begin
                build_hdr(seq);
                seq = seq + 16'd1;
                send_pkt(1'b0);
            end else begin
                if ($urandom_range(0, 3) == 0) seq = 16'($urandom);
                build_hdr(seq);
                seq = seq + 16'd1;
                add_payload($urandom_range(1, 20));
                send_pkt($urandom_range(0, 5) == 0);
            end
            verify($sformatf("rand%0d", p));
        end

        // Reset in the middle of a packet, then a clean packet.
        gaps = 1'b0;
        build_hdr(16'h1234); add_payload(8);
        for (int i = 0; i < 6; i++) send_byte(pkt[i], 1'b0, 1'b0);
        do_reset("mid_pkt");
        build_hdr(16'h0050); add_payload(5); send_pkt(1'b0);
        verify("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/udp_payload_deframer.md
UDP_PAYLOAD_DEFRAMER -- requirements
Module: udp_payload_deframer

Interface
REQ-001 SHALL have parameter MAGIC, default 16'hD0A5, the required first two payload bytes (big-endian).
REQ-002 SHALL have parameter CHECK_SEQ, default 1, where 1 enables sequence-gap detection.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have ports s_axis_tdata/tvalid/tready/tlast/tuser, in/in/out/in/in, 8/1/1/1/1, the UDP RX payload byte stream.
REQ-006 SHALL have ports m_axis_tdata/tkeep/tvalid/tready/tlast/tuser, out/out/out/in/out/out, 32/4/1/1/1/1, the packed sample-word stream.
REQ-007 SHALL have port last_seq, output, 16, the sequence number of the most recent accepted packet.
REQ-008 SHALL have ports stat_pkt_ok, stat_pkt_bad and stat_seq_gap, each output, 1, single-cycle event pulses.

Function
REQ-009 SHALL define the packet format as: bytes 0-1 MAGIC, bytes 2-3 sequence number (big-endian), bytes 4..N-1 payload.
REQ-010 SHALL implement FSM states HDR0, HDR1, SEQ0, SEQ1, PAYLOAD and DROP, and SHALL enter HDR0 after reset.
REQ-011 SHALL, in HDR0/HDR1, advance on a byte matching MAGIC[15:8]/MAGIC[7:0], and otherwise go to DROP.
REQ-012 SHALL latch the sequence number in SEQ0/SEQ1, then go to PAYLOAD.
REQ-013 SHALL, if a header byte carries tlast, pulse stat_pkt_bad, emit no words, and return to HDR0.
REQ-014 SHALL, in DROP, consume bytes with tready=1 until tlast, then pulse stat_pkt_bad and return to HDR0.
REQ-015 SHALL hold s_axis_tready=1 in all header states and in DROP.
REQ-016 SHALL hold s_axis_tready=0 in PAYLOAD only while a completed word is held and m_axis_tready=0.
REQ-017 SHALL pack payload bytes big-endian: 1st byte to [31:24], 2nd to [23:16], 3rd to [15:8], 4th to [7:0].
REQ-018 SHALL assert m_axis_tvalid on the cycle after the 4th byte, or the tlast byte, is accepted (latency 1).
REQ-019 SHALL, for a short final word, left-justify the data, zero unused bytes, and set tkeep to 4'b1000, 4'b1100 or 4'b1110.
REQ-020 SHALL set m_axis_tlast on the word containing the tlast byte.
REQ-021 SHALL set m_axis_tuser on that word when s_axis_tuser is set with tlast.
REQ-022 SHALL hold m_axis_tdata, tkeep, tlast and tuser stable while tvalid=1 and tready=0.
REQ-023 SHALL, for a packet whose tlast lands on the final SEQ1 byte (header only), emit no words, update last_seq and pulse stat_pkt_ok.
REQ-024 SHALL, at the tlast of a PAYLOAD packet, pulse stat_pkt_bad if tuser=1, else pulse stat_pkt_ok and update last_seq.
REQ-025 SHALL treat tuser on non-tlast bytes as don't-care.
REQ-026 SHALL, with CHECK_SEQ=1, pulse stat_seq_gap on a good packet whose seq is not (previous good seq + 1) mod 2^16.
REQ-027 SHALL never pulse stat_seq_gap on the first good packet after reset, and SHALL treat 16'hFFFF followed by 16'h0000 as no gap.
REQ-028 SHALL, when a packet's tlast byte is accepted while the previous word is still held, accept the next packet's HDR0 byte in the following cycle with no bubble.

Reset
REQ-029 SHALL, on rst_n=0, immediately clear m_axis_tvalid, tdata, tkeep, tlast and tuser, last_seq, the stat_* pulses, the packing state and the seen-first-packet flag, and set the FSM to HDR0.
REQ-030 SHALL, on reset mid-packet, discard the remainder, with the next byte after reset release treated as HDR0.
REQ-031 SHALL hold s_axis_tready=0 while rst_n=0.

Structure
REQ-032 SHALL place the FSM state encoding and the MAGIC default constant in a shared package, udp_deframer_pkg.
REQ-033 SHALL implement byte-to-word packing, tkeep generation and the output hold register in one sub-module, byte_packer_32.

Verification
REQ-034 SHALL cover this case: bytes D0 A5 00 07 11 22 33 44 55 66 77 88 (tlast on 88) -> words 11223344/F, 55667788/F with tlast, stat_pkt_ok pulse, last_seq=0x0007.
REQ-035 SHALL cover this case: D0 A5 00 08 AA BB CC DD EE (tlast) -> words AABBCCDD/F, EE000000/4'b1000 with tlast.
REQ-036 SHALL cover this case: packet starting D0 A6 (6 bytes) -> all bytes accepted, no words, stat_pkt_bad pulse, last_seq unchanged.
REQ-037 SHALL cover this case: good packets with seq FFFF, 0000, 0002 -> stat_seq_gap only on 0002.
REQ-038 SHALL cover this case: m_axis_tready toggling 50% random on a 64-byte payload -> 16 words in order, data stable while stalled, no loss.
REQ-039 SHALL cover this case: rst_n low after the 6th byte of a packet, then a fresh good packet -> no output from the first packet, second packet output exact.
